// File: rtl/x2z_row_feeder.sv
// Input stage of the x-to-z transform array: buffers scalar samples into N-sample
// ping-pong blocks and streams mirrored pairs (x[k], x[N-1-k]) as a sum pass then a difference pass.
module x2z_row_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] pe_x,
  output logic [DATA_WIDTH-1:0] pe_z,
  output logic                  pe_sumDiffSel,
  output logic                  pe_load,
  output logic                  pe_valid,
  output logic                  busy
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] HALF_LAST = IDX_W'(N / 2 - 1);

  typedef enum logic [1:0] {IDLE, SUM, DIFF} state_t;

  logic [DATA_WIDTH-1:0] mem [2][N];
  logic [1:0]            full;
  logic                  wr_bank;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_fire;
  logic                  wr_last;

  state_t                state, state_next;
  logic                  rd_bank;
  logic [IDX_W-1:0]      k, k_next, k_cur;
  logic                  emit;
  logic                  sel;
  logic                  rd_clear;
  logic [DATA_WIDTH-1:0] rd_x, rd_z;

  assign s_ready = !full[wr_bank];
  assign wr_fire = s_valid && s_ready;
  assign wr_last = wr_fire && (wr_idx == LAST_IDX);
  assign busy    = (|full) || (state != IDLE);

  // NOTE: sample storage has no reset; the full flags alone decide whether its contents are meaningful.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_idx] <= s_data;
  end

  // NOTE: registered state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (wr_fire) begin
      if (wr_idx == LAST_IDX) begin
        wr_bank <= !wr_bank;
        wr_idx  <= '0;
      end else begin
        wr_idx <= wr_idx + IDX_W'(1);
      end
    end
  end

  // Set and clear always target different banks, so both may fire on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (rd_clear) full[rd_bank] <= 1'b0;
      if (wr_last)  full[wr_bank] <= 1'b1;
    end
  end

  // An IDLE cycle that sees a full bank emits the first sum beat itself, giving
  // two-cycle latency from the last sample to the first beat.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    k_next     = k;
    k_cur      = k;
    emit       = 1'b0;
    sel        = 1'b0;
    rd_clear   = 1'b0;
    unique case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          emit  = 1'b1;
          k_cur = '0;
        end
      end
      SUM:  emit = 1'b1;
      DIFF: begin
        emit = 1'b1;
        sel  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (emit) begin
      if (k_cur != HALF_LAST) begin
        k_next     = k_cur + IDX_W'(1);
        state_next = sel ? DIFF : SUM;
      end else if (!sel) begin
        k_next     = '0;
        state_next = DIFF;
      end else begin
        k_next     = '0;
        rd_clear   = 1'b1;
        state_next = full[!rd_bank] ? SUM : IDLE;
      end
    end
  end

  assign rd_x = mem[rd_bank][k_cur];
  assign rd_z = mem[rd_bank][LAST_IDX - k_cur];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      rd_bank <= 1'b0;
    end else begin
      state <= state_next;
      k     <= k_next;
      if (rd_clear) rd_bank <= !rd_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_x          <= '0;
      pe_z          <= '0;
      pe_sumDiffSel <= 1'b0;
      pe_load       <= 1'b0;
      pe_valid      <= 1'b0;
    end else begin
      pe_valid      <= emit;
      pe_load       <= emit && !sel && (k_cur == '0);
      pe_sumDiffSel <= emit && sel;
      if (emit) begin
        pe_x <= rd_x;
        pe_z <= rd_z;
      end
    end
  end

endmodule

// File: tb/tb_x2z_row_feeder.sv
// Scoreboard bench for x2z_row_feeder: an N=8 and an N=2 instance, directed sample
// vectors, expected beats (with exact cycle) queued on acceptance and checked by a monitor.
module tb_x2z_row_feeder;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  z;
    logic        sel;
    logic        load;
    logic [31:0] cyc;
  } beat_t;

  localparam int NS [2] = '{8, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cyc = 0;
  logic        s_valid_a [2];
  logic [7:0]  s_data_a  [2];
  logic        s_ready_a [2];
  logic [7:0]  pe_x_a    [2];
  logic [7:0]  pe_z_a    [2];
  logic        pe_sel_a  [2];
  logic        pe_load_a [2];
  logic        pe_valid_a[2];
  logic        busy_a    [2];

  beat_t       exp_q [2][$];
  logic [7:0]  blk   [2][8];
  int          cnt   [2];
  logic [31:0] next_free [2];
  int          checks = 0;
  int          passed = 0;
  int          stalls = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  x2z_row_feeder #(.DATA_WIDTH(8), .N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_a[0]), .s_valid(s_valid_a[0]),
    .s_ready(s_ready_a[0]), .pe_x(pe_x_a[0]), .pe_z(pe_z_a[0]),
    .pe_sumDiffSel(pe_sel_a[0]), .pe_load(pe_load_a[0]), .pe_valid(pe_valid_a[0]),
    .busy(busy_a[0]));

  x2z_row_feeder #(.DATA_WIDTH(8), .N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_a[1]), .s_valid(s_valid_a[1]),
    .s_ready(s_ready_a[1]), .pe_x(pe_x_a[1]), .pe_z(pe_z_a[1]),
    .pe_sumDiffSel(pe_sel_a[1]), .pe_load(pe_load_a[1]), .pe_valid(pe_valid_a[1]),
    .busy(busy_a[1]));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic flag(input string name, input logic [63:0] info);
    checks++;
    $display("FAIL %s: info %h (cycle %0d)", name, info, cyc);
  endtask

  // Reference model: once a block is complete, queue its 2*(N/2) beats with exact cycles.
  task automatic accept(input int d, input logic [7:0] v, input logic [31:0] t);
    int half;
    logic [31:0] start;
    beat_t b;
    blk[d][cnt[d]] = v;
    cnt[d]++;
    if (cnt[d] == NS[d]) begin
      half  = NS[d] / 2;
      start = (t + 2 > next_free[d]) ? t + 2 : next_free[d];
      for (int p = 0; p < 2; p++) begin
        for (int kk = 0; kk < half; kk++) begin
          b.x    = blk[d][kk];
          b.z    = blk[d][NS[d] - 1 - kk];
          b.sel  = (p == 1);
          b.load = (p == 0) && (kk == 0);
          b.cyc  = start + 32'(p * half + kk);
          exp_q[d].push_back(b);
        end
      end
      next_free[d] = start + 32'(NS[d]);
      cnt[d] = 0;
    end
  endtask

  task automatic send(input int d, input logic [7:0] v);
    int w = 0;
    @(negedge clk);
    s_valid_a[d] = 1'b1;
    s_data_a[d]  = v;
    while (!s_ready_a[d] && w < 50) begin
      stalls++;
      @(negedge clk);
      w++;
    end
    if (w == 50) flag("send_timeout", 64'(v));
    else accept(d, v, cyc);
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid_a[d] = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("drain_q8", 64'(exp_q[0].size()), 64'd0);
    check("drain_q2", 64'(exp_q[1].size()), 64'd0);
  endtask

  // Asserted away from any clock edge; outputs must clear before the next edge.
  task automatic apply_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_outputs_zero",
            {45'd0, pe_valid_a[d], pe_load_a[d], pe_sel_a[d], pe_x_a[d], pe_z_a[d]}, 64'd0);
      exp_q[d].delete();
      cnt[d] = 0;
      next_free[d] = 0;
      s_valid_a[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("post_reset_ready_busy", {62'd0, s_ready_a[d], busy_a[d]}, 64'd2);
    end
  endtask

  // Monitor: pops one expected beat per presented beat; also catches missing or stray beats.
  always @(negedge clk) begin
    beat_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        if (pe_valid_a[d]) begin
          if (exp_q[d].size() == 0) begin
            flag("unexpected_beat", {48'd0, pe_x_a[d], pe_z_a[d]});
          end else begin
            e = exp_q[d].pop_front();
            check(d == 0 ? "beat_n8" : "beat_n2",
                  {14'd0, pe_x_a[d], pe_z_a[d], pe_sel_a[d], pe_load_a[d], cyc},
                  {14'd0, e});
          end
        end else if (exp_q[d].size() != 0 && exp_q[d][0].cyc < cyc) begin
          e = exp_q[d].pop_front();
          flag("missing_beat", {14'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_valid_a[d] = 1'b0;
      s_data_a[d]  = 8'd0;
      cnt[d]       = 0;
      next_free[d] = 0;
    end
    apply_reset();

    // Single block 1..8: pairs (1,8),(2,7),(3,6),(4,5) sum then diff, first beat at t+2.
    for (int i = 1; i <= 8; i++) send(0, 8'(i));
    idle(0, 1);
    drain();

    // Four gapless blocks 0..31: no stalls, 32 contiguous beats.
    stalls = 0;
    for (int i = 0; i < 32; i++) send(0, 8'(i));
    idle(0, 1);
    drain();
    check("stream_no_stall", 64'(stalls), 64'd0);

    // Gapped input: five idle cycles after the third sample.
    for (int i = 21; i <= 23; i++) send(0, 8'(i));
    idle(0, 5);
    for (int i = 24; i <= 28; i++) send(0, 8'(i));
    idle(0, 1);
    drain();

    // Reset while a block is being emitted: remaining beats must never appear.
    for (int i = 100; i <= 107; i++) send(0, 8'(i));
    idle(0, 4);
    apply_reset();
    repeat (12) @(negedge clk);

    // Reset mid-fill: five samples discarded, only block 10..17 emitted.
    for (int i = 50; i <= 54; i++) send(0, 8'(i));
    idle(0, 1);
    apply_reset();
    for (int i = 10; i <= 17; i++) send(0, 8'(i));
    idle(0, 1);
    drain();

    // N = 2: samples 5, 9 -> (5,9) sum with load, then (5,9) diff.
    send(1, 8'd5);
    send(1, 8'd9);
    idle(1, 1);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
